// File: rtl/neural_net_pkg.sv
// Shared constants, FSM encodings and byte-lane helper for the neural_net
// AXI4-Lite register block.
package neural_net_pkg;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam int         REG_IDX_W     = 2;
   localparam int         ADDR_LSB      = 2;
   localparam int         NUM_REGS      = 1 << REG_IDX_W;

   typedef enum logic [1:0] {
      W_IDLE      = 2'd0,
      W_HAVE_ADDR = 2'd1,
      W_HAVE_DATA = 2'd2,
      W_RESP      = 2'd3
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   // Replace only the byte lanes whose strobe bit is set.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/neural_net_axil_regs.sv
// AXI4-Lite slave holding four 32-bit R/W registers for the neuron compute
// core. Independent write (4-state) and read (2-state) FSMs; every access
// answers OKAY. Registers and a one-cycle write pulse go to the core.
module neural_net_axil_regs
   import neural_net_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_o,
   output logic [NUM_REGS-1:0]             wr_pulse_o
);

   // Write channel state and the half-transaction it may be holding
   wr_state_e                wr_state_q, wr_state_d;
   logic [REG_IDX_W-1:0]     wr_idx_q, wr_idx_d;
   logic [31:0]              wdata_q, wdata_d;
   logic [3:0]               wstrb_q, wstrb_d;

   // Register file and core-facing pulse
   logic [31:0]              regs_q [NUM_REGS];
   logic [31:0]              regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]      wr_pulse_q, wr_pulse_d;

   // Read channel
   rd_state_e                rd_state_q, rd_state_d;
   logic [31:0]              rdata_q, rdata_d;

   logic                     aw_hs, w_hs, ar_hs;
   logic                     commit;
   logic [REG_IDX_W-1:0]     commit_idx;
   logic [31:0]              commit_data;
   logic [3:0]               commit_strb;
   logic [REG_IDX_W-1:0]     aw_idx, ar_idx;

   // Protection bits and the byte-offset address bits carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                          S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

   assign aw_idx = S_AXI_AWADDR[ADDR_LSB +: REG_IDX_W];
   assign ar_idx = S_AXI_ARADDR[ADDR_LSB +: REG_IDX_W];
   assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID  & S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;

   // Write FSM state register
   always_ff @(posedge S_AXI_ACLK) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values regardless of statement order.
      if (S_AXI_ARESET) wr_state_q <= W_IDLE;
      else              wr_state_q <= wr_state_d;
   end

   // Write FSM next state, half-transaction capture and commit decode
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      wr_state_d  = wr_state_q;
      wr_idx_d    = wr_idx_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      commit      = 1'b0;
      commit_idx  = aw_idx;
      commit_data = S_AXI_WDATA;
      commit_strb = S_AXI_WSTRB;
      unique case (wr_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit     = 1'b1;
               wr_state_d = W_RESP;
            end else if (aw_hs) begin
               wr_idx_d   = aw_idx;
               wr_state_d = W_HAVE_ADDR;
            end else if (w_hs) begin
               wdata_d    = S_AXI_WDATA;
               wstrb_d    = S_AXI_WSTRB;
               wr_state_d = W_HAVE_DATA;
            end
         end
         W_HAVE_ADDR: begin
            commit_idx = wr_idx_q;
            if (w_hs) begin
               commit     = 1'b1;
               wr_state_d = W_RESP;
            end
         end
         W_HAVE_DATA: begin
            commit_data = wdata_q;
            commit_strb = wstrb_q;
            if (aw_hs) begin
               commit     = 1'b1;
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) wr_state_d = W_IDLE;
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   // Write FSM outputs; readys held low throughout reset
   always_comb begin
      S_AXI_AWREADY = 1'b0;
      S_AXI_WREADY  = 1'b0;
      S_AXI_BVALID  = 1'b0;
      unique case (wr_state_q)
         W_IDLE:      begin S_AXI_AWREADY = 1'b1; S_AXI_WREADY = 1'b1; end
         W_HAVE_ADDR: S_AXI_WREADY  = 1'b1;
         W_HAVE_DATA: S_AXI_AWREADY = 1'b1;
         W_RESP:      S_AXI_BVALID  = 1'b1;
         default:     ;
      endcase
      if (S_AXI_ARESET) begin
         S_AXI_AWREADY = 1'b0;
         S_AXI_WREADY  = 1'b0;
      end
   end

   // Register file update and write pulse for the committing register
   always_comb begin
      regs_d     = regs_q;
      wr_pulse_d = '0;
      if (commit) begin
         regs_d[commit_idx]     = byte_merge(regs_q[commit_idx], commit_data, commit_strb);
         wr_pulse_d[commit_idx] = 1'b1;
      end
   end

   // Read FSM next state; capture uses pre-commit register contents
   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      unique case (rd_state_q)
         R_IDLE: if (ar_hs) begin
            rdata_d    = regs_q[ar_idx];
            rd_state_d = R_DATA;
         end
         R_DATA: if (S_AXI_RREADY) rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase
   end

   // Read FSM outputs
   always_comb begin
      S_AXI_ARREADY = (rd_state_q == R_IDLE) && !S_AXI_ARESET;
      S_AXI_RVALID  = (rd_state_q == R_DATA);
   end

   // Read FSM state register
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) rd_state_q <= R_IDLE;
      else              rd_state_q <= rd_state_d;
   end

   // Datapath flops: register file, capture buffers, pulse and read data
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         // NOTE: the register file is only four words and software expects
         // zeros after reset, so it is reset explicitly like any other flop.
         regs_q     <= '{default: '0};
         wr_idx_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         wr_pulse_q <= '0;
         rdata_q    <= '0;
      end else begin
         regs_q     <= regs_d;
         wr_idx_q   <= wr_idx_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         wr_pulse_q <= wr_pulse_d;
         rdata_q    <= rdata_d;
      end
   end

   assign S_AXI_BRESP = AXI_RESP_OKAY;
   assign S_AXI_RRESP = AXI_RESP_OKAY;
   assign S_AXI_RDATA = rdata_q;
   assign wr_pulse_o  = wr_pulse_q;
   assign regs_o      = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

endmodule
